// File: rtl/prb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prb_pkg
//  Brief    : Shared widths, FSM states and byte-packing bounds for the
//             parameter-registry load path.
//  Revision : 1.0  initial release
// ============================================================================
package prb_pkg;

    localparam int MASK_W = 11;
    localparam int CODE_W = 11;
    localparam int SJW_W  = 2;

    // Field bounds of the three-byte stream; the registry unpacks with these.
    localparam int B0_MASK_MSB = 7;
    localparam int B1_MASK_LSB = 8;
    localparam int B1_MASK_MSB = 10;
    localparam int B1_CODE_MSB = 4;
    localparam int B2_CODE_LSB = 5;
    localparam int B2_CODE_MSB = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND_ID = 3'd1,
        ST_BYTE0   = 3'd2,
        ST_BYTE1   = 3'd3,
        ST_BYTE2   = 3'd4,
        ST_SETTLE  = 3'd5,
        ST_CHECK   = 3'd6
    } prb_state_e;

    function automatic logic [7:0] pack_byte(
        input logic [1:0]        sel,
        input logic [MASK_W-1:0] mask,
        input logic [CODE_W-1:0] code,
        input logic [SJW_W-1:0]  sjw
    );
        logic [7:0] b;
        case (sel)
            2'd0:    b = mask[B0_MASK_MSB:0];
            2'd1:    b = {code[B1_CODE_MSB:0], mask[B1_MASK_MSB:B1_MASK_LSB]};
            2'd2:    b = {sjw, code[B2_CODE_MSB:B2_CODE_LSB]};
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prb_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : prb_rr_arb2
//  Brief    : Two-way round-robin arbiter; pointer moves only on advance.
//  Revision : 1.0  initial release
// ============================================================================
module prb_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // ptr_q = 1 gives requester 1 priority on a tie
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        if (advance && (gnt != 2'b00)) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prb_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : prb_cfg_ctrl
//  Brief    : Arbitrates two requesters, streams mask/code/sjw to the
//             parameter registry and verifies the readback with retries.
//  Revision : 1.0  initial release
// ============================================================================
module prb_cfg_ctrl
    import prb_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int MAX_RETRY  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [MASK_W-1:0] req0_mask,
    input  logic [MASK_W-1:0] req1_mask,
    input  logic [CODE_W-1:0] req0_code,
    input  logic [CODE_W-1:0] req1_code,
    input  logic [SJW_W-1:0]  req0_sjw,
    input  logic [SJW_W-1:0]  req1_sjw,
    output logic [1:0]        gnt,
    output logic              param_id,
    output logic [7:0]        data,
    input  logic [MASK_W-1:0] rb_mask,
    input  logic [CODE_W-1:0] rb_code,
    input  logic [SJW_W-1:0]  rb_sjw,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              done_id
);

    localparam logic [3:0] c_settle_init = 4'(SETTLE_CYC - 1);
    localparam logic [1:0] c_max_retry   = 2'(MAX_RETRY);

    prb_state_e        state_q, state_d;
    logic              idx_q, idx_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [SJW_W-1:0]  sjw_q, sjw_d;
    logic [1:0]        retry_q, retry_d;
    logic [3:0]        settle_q, settle_d;

    logic [1:0]        w_arb_gnt;
    logic              w_arb_adv;
    logic              w_rb_match;

    prb_rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (w_arb_adv),
        .gnt     (w_arb_gnt)
    );

    assign w_rb_match = (rb_mask == mask_q) && (rb_code == code_q) && (rb_sjw == sjw_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        code_d    = code_q;
        sjw_d     = sjw_q;
        retry_d   = retry_q;
        settle_d  = settle_q;
        w_arb_adv = 1'b0;
        gnt       = 2'b00;
        param_id  = 1'b0;
        data      = 8'h00;
        done      = 1'b0;
        err       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Reset gating keeps gnt quiet while reset is held in IDLE.
                if (!reset && (w_arb_gnt != 2'b00)) begin
                    gnt       = w_arb_gnt;
                    w_arb_adv = 1'b1;
                    idx_d     = w_arb_gnt[1];
                    mask_d    = w_arb_gnt[1] ? req1_mask : req0_mask;
                    code_d    = w_arb_gnt[1] ? req1_code : req0_code;
                    sjw_d     = w_arb_gnt[1] ? req1_sjw  : req0_sjw;
                    retry_d   = 2'd0;
                    state_d   = ST_SEND_ID;
                end
            end
            ST_SEND_ID: begin
                param_id = 1'b1;
                state_d  = ST_BYTE0;
            end
            ST_BYTE0: begin
                data    = pack_byte(2'd0, mask_q, code_q, sjw_q);
                state_d = ST_BYTE1;
            end
            ST_BYTE1: begin
                data    = pack_byte(2'd1, mask_q, code_q, sjw_q);
                state_d = ST_BYTE2;
            end
            ST_BYTE2: begin
                data     = pack_byte(2'd2, mask_q, code_q, sjw_q);
                settle_d = c_settle_init;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_CHECK: begin
                if (w_rb_match) begin
                    done    = !reset;
                    state_d = ST_IDLE;
                end else if (retry_q < c_max_retry) begin
                    retry_d = retry_q + 2'd1;
                    state_d = ST_SEND_ID;
                end else begin
                    err     = !reset;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy    = (state_q != ST_IDLE);
        done_id = (done | err) & idx_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= 1'b0;
            mask_q   <= '0;
            code_q   <= '0;
            sjw_q    <= '0;
            retry_q  <= 2'd0;
            settle_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            code_q   <= code_d;
            sjw_q    <= sjw_d;
            retry_q  <= retry_d;
            settle_q <= settle_d;
        end
    end

endmodule
`default_nettype wire
